// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG row-sequencing front end.
// Holds the default geometry of an 8x8 block and the row sequencer state encoding.
package jpeg_pkg;

   localparam int DW           = 8;
   localparam int N            = 8;
   localparam int ROWS         = 8;
   localparam int LEVEL_OFFSET = 128;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      FIRE = 2'd1,
      WAIT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/dct_row_buf.sv
// Row buffer of N register lanes feeding the DCT engine inputs.
// One lane is written per cycle at the given index; all lanes are presented flattened.
module dct_row_buf #(
   parameter int DW = 8,
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [IW-1:0]   idx,
   input  logic [DW-1:0]   din,
   output logic [N*DW-1:0] dout
);

   logic [DW-1:0] lane [N];

   // NOTE: these lanes are a small register bank, not a RAM, so they can be
   // cleared by reset; row_data has to read zero while rst is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N; k++) lane[k] <= '0;
      end else if (we) begin
         lane[idx] <= din;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign dout[k*DW +: DW] = lane[k];
   end

endmodule

// File: rtl/dct_row_seq.sv
// Row sequencer for the JPEG 1-D DCT stage: packs level-shifted pixels into rows,
// fires the DCT engine once per row, frames 8x8 blocks and flags protocol errors.
module dct_row_seq #(
   parameter int DW          = jpeg_pkg::DW,
   parameter int N           = jpeg_pkg::N,
   parameter int ROWS        = jpeg_pkg::ROWS,
   parameter bit LEVEL_SHIFT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   pix_in,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic [N*DW-1:0] row_data,
   output logic            dct_start,
   input  logic            dct_done,
   output logic [2:0]      row_idx,
   output logic            blk_start,
   output logic            blk_done,
   output logic            seq_err
);

   import jpeg_pkg::*;

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   seq_state_t    state, state_nxt;
   logic [CW-1:0] col;
   logic [2:0]    row;
   logic          accept;
   logic          last_col;
   logic          last_row;
   logic [DW-1:0] lane_din;

   assign accept    = pix_valid && (state == FILL) && !rst;
   assign last_col  = (col == CW'(N - 1));
   assign last_row  = (row == 3'(ROWS - 1));
   assign blk_start = accept && (row == 3'd0) && (col == '0);
   assign row_idx   = row;

   // Level shift by 2^(DW-1) is just an MSB flip in two's complement.
   assign lane_din = LEVEL_SHIFT ? {~pix_in[DW-1], pix_in[DW-2:0]} : pix_in;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      dct_start = 1'b0;
      blk_done  = 1'b0;
      case (state)
         FILL: begin
            pix_ready = !rst;
            if (accept && last_col) state_nxt = FIRE;
         end
         FIRE: begin
            dct_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (dct_done) begin
               blk_done  = last_row && !rst;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else begin
         if (accept) col <= last_col ? '0 : col + 1'b1;
         if (state == WAIT && dct_done) row <= last_row ? 3'd0 : row + 3'd1;
      end
   end

   // A completion pulse is only legal while waiting on the engine.
   always_ff @(posedge clk) begin
      if (rst)                           seq_err <= 1'b0;
      else if (dct_done && state != WAIT) seq_err <= 1'b1;
   end

   dct_row_buf #(
      .DW (DW),
      .N  (N),
      .IW (CW)
   ) u_row_buf (
      .clk  (clk),
      .rst  (rst),
      .we   (accept),
      .idx  (col),
      .din  (lane_din),
      .dout (row_data)
   );

endmodule

// File: doc/dct_row_seq.md
# dct_row_seq

Row sequencer for the JPEG 1-D DCT stage. Accepts a raster stream of 8-bit pixels over a valid/ready handshake and level-shifts each sample. Packs eight samples into a row buffer whose lanes feed the DCT engine inputs, fires the engine once per row and waits for its completion. Counts rows to frame 8x8 blocks, and reports blocks and protocol errors to the surrounding compression pipeline.

## Interface
Parameters:
- DW, 8, pixel width
- N, 8, samples per row (lanes)
- ROWS, 8, rows per block
- LEVEL_SHIFT, 1, 1 = store pix-128 (MSB inverted), 0 = store raw

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  DW  incoming pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  sequencer can accept a pixel
- row_data  out  N*DW  lane k at bits [k*DW +: DW], lane 0 = first pixel of row
- dct_start  out  1  one-cycle pulse, row_data valid and stable
- dct_done  in  1  engine finished current row (one-cycle pulse)
- row_idx  out  3  row currently loading/processing (0..ROWS-1)
- blk_start  out  1  pulse: first pixel of a block accepted
- blk_done  out  1  pulse: last row of block completed
- seq_err  out  1  sticky protocol error

## Operation
- States: FILL, FIRE, WAIT. Reset state FILL; col=0, row=0.
- FILL: pix_ready=1. Accept on pix_valid&&pix_ready: lane[col] <= LEVEL_SHIFT ? {~pix_in[DW-1], pix_in[DW-2:0]} : pix_in; col++. Accept with col==N-1 -> col=0, go FIRE.
- FIRE: pix_ready=0, dct_start=1 for exactly this cycle, go WAIT.
- WAIT: pix_ready=0; row_data held unchanged. On dct_done: if row==ROWS-1 then blk_done=1 this cycle, row=0; else row++. Go FILL.
- blk_start=1 in the cycle an accept occurs with row==0 && col==0.
- dct_done outside WAIT (including the FIRE cycle) is ignored for sequencing and sets seq_err=1. seq_err is cleared only by rst.
- pix_valid while pix_ready=0: no effect. The source must hold data, which follows standard valid/ready rules.
- row_data lanes are never cleared between rows; stale lanes are overwritten during FILL.

## Timing
- While rst=1: pix_ready=0, dct_start=0, blk_start=0, blk_done=0, seq_err=0, row_idx=0, row_data=0, state FILL.
- First cycle after rst deasserts: pix_ready=1.
- rst mid-row or mid-WAIT: partial row is discarded and the next accepted pixel is row 0 col 0. A dct_done arriving after reset is an error (seq_err).
- dct_start is registered and asserts in the cycle after the Nth accept.
- The earliest legal dct_done is the cycle after dct_start.
- The sequencer can accept pixels in the cycle after the dct_done cycle.
- Minimum row period = N + 2 + engine latency cycles. Full throughput with continuous valid: N accepts back-to-back.
- blk_done coincides with the cycle dct_done is sampled for row ROWS-1.
- row_idx changes on the clock edge after that dct_done.
- Simultaneous blk_start and blk_done are impossible, because accepts are blocked in WAIT.

## Structure
- Shared package jpeg_pkg: DW, N, ROWS, LEVEL_OFFSET (128), and the state enum {FILL, FIRE, WAIT}.
- Sub-module dct_row_buf: N x DW register lanes with write-enable, lane index and synchronous reset, flattened output. FSM, counters and flags stay in dct_row_seq.

## Test plan
- Reset then stream 0..7 with continuous valid:
  - row_data lanes 0..7 = 0x80..0x87 (LEVEL_SHIFT=1).
  - dct_start pulses in the cycle after the 8th accept.
  - pix_ready=0 until dct_done.
- Full block:
  - 64 pixels, dct_done 3 cycles after each dct_start.
  - 8 dct_start pulses, row_idx steps 0..7.
  - blk_start once, on the first accept.
  - blk_done once, on the 8th dct_done.
  - Then row_idx=0.
- Gapped valid (valid toggles every cycle) with pixel 0xFF: lane = 0x7F. Accept count and row timing follow only valid&&ready cycles.
- dct_done pulsed during FILL, and again in the FIRE cycle: seq_err=1 and stays 1, with no row advance. rst then clears it to 0.
- Assert rst after 5 pixels of row 3:
  - all outputs go to reset values.
  - Next 8 pixels fire row 0.
  - blk_start asserts on the first of them.
- LEVEL_SHIFT=0: pixels 0x00 and 0x80 are stored unchanged in lanes 0 and 1.
